// File: rtl/disp_reg_initiator.sv
// ---------------------------------------------------------------------------
// disp_reg_initiator
//
// Purpose:
//   Turns single requester commands (register read or write) into one
//   register-bus transaction at a time. The bus valid is held until the
//   responder acknowledges or until TIMEOUT_CYCLES cycles have elapsed. The
//   outcome (read data, or a timeout flag) is then presented as a response
//   that the requester must consume before the next command is accepted.
//
// Parameters:
//   TIMEOUT_CYCLES  maximum cycles a bus valid is held awaiting ack (1..65535)
//
// Ports:
//   iClock          clock, rising-edge
//   iReset          asynchronous active-low reset
//   iCmdValid       command valid from requester
//   iCmdWrite       1 = write, 0 = read
//   iCmdAddress     register address
//   iCmdData        write data
//   oCmdReady       high only while idle
//   oWriteAddress   register-bus write address
//   oWriteData      register-bus write data
//   oWriteValid     register-bus write request
//   iWriteAck       responder write acknowledge
//   oReadAddress    register-bus read address
//   oReadValid      register-bus read request
//   iReadData       responder read data (valid with iReadAck)
//   iReadAck        responder read acknowledge
//   oRspValid       response available
//   oRspData        captured read data (0 for writes and timeouts)
//   oRspTimeout     response is the result of a timeout
//   iRspReady       requester consumes the response
//   oTimeoutCount   saturating count of timed-out transactions
// ---------------------------------------------------------------------------
module disp_reg_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic        iCmdValid,
    input  logic        iCmdWrite,
    input  logic [31:0] iCmdAddress,
    input  logic [31:0] iCmdData,
    output logic        oCmdReady,
    output logic [31:0] oWriteAddress,
    output logic [31:0] oWriteData,
    output logic        oWriteValid,
    input  logic        iWriteAck,
    output logic [31:0] oReadAddress,
    output logic        oReadValid,
    input  logic [31:0] iReadData,
    input  logic        iReadAck,
    output logic        oRspValid,
    output logic [31:0] oRspData,
    output logic        oRspTimeout,
    input  logic        iRspReady,
    output logic [7:0]  oTimeoutCount
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Wait-counter value of the last cycle a valid may be held.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_timeout_q, rsp_timeout_d;
    logic [15:0] wait_q, wait_d;
    logic [7:0]  tcount_q, tcount_d;

    logic        ack;
    logic        timed_out;

    // Only the ack matching the direction of the outstanding request counts;
    // an ack arriving in the final wait cycle takes priority over timeout.
    always_comb begin
        ack       = ((state_q == WRITE) && iWriteAck) ||
                    ((state_q == READ)  && iReadAck);
        timed_out = ((state_q == WRITE) || (state_q == READ)) &&
                    !ack && (wait_q == WAIT_LAST);
    end

    // State and datapath registers.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
            wait_q        <= '0;
            tcount_q      <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rsp_data_q    <= rsp_data_d;
            rsp_timeout_q <= rsp_timeout_d;
            wait_q        <= wait_d;
            tcount_q      <= tcount_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (iCmdValid) begin
                    state_d = iCmdWrite ? WRITE : READ;
                end
            end
            WRITE, READ: begin
                if (ack || timed_out) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (iRspReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: command capture, wait counting, response capture and the
    // saturating timeout counter.
    always_comb begin
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rsp_data_d    = rsp_data_q;
        rsp_timeout_d = rsp_timeout_q;
        wait_d        = wait_q;
        tcount_d      = tcount_q;
        case (state_q)
            IDLE: begin
                if (iCmdValid) begin
                    addr_d  = iCmdAddress;
                    wdata_d = iCmdData;
                    wait_d  = '0;
                end
            end
            WRITE, READ: begin
                if (ack) begin
                    rsp_data_d    = (state_q == READ) ? iReadData : 32'd0;
                    rsp_timeout_d = 1'b0;
                end else if (timed_out) begin
                    rsp_data_d    = 32'd0;
                    rsp_timeout_d = 1'b1;
                    if (tcount_q != 8'hFF) begin
                        tcount_d = tcount_q + 8'd1;
                    end
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            default: ;
        endcase
    end

    // Outputs are pure functions of registered state.
    always_comb begin
        oCmdReady     = (state_q == IDLE);
        oWriteValid   = (state_q == WRITE);
        oReadValid    = (state_q == READ);
        oRspValid     = (state_q == RESP);
        oWriteAddress = addr_q;
        oWriteData    = wdata_q;
        oReadAddress  = addr_q;
        oRspData      = rsp_data_q;
        oRspTimeout   = rsp_timeout_q;
        oTimeoutCount = tcount_q;
    end

endmodule

// File: tb/tb_disp_reg_initiator.sv
// ---------------------------------------------------------------------------
// tb_disp_reg_initiator
//
// Purpose:
//   Directed self-checking bench for disp_reg_initiator with a four-cycle
//   timeout. Expected responses are queued when a command is issued and
//   popped when the response handshake happens. Inputs are driven and outputs
//   sampled on the falling clock edge.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_disp_reg_initiator;

    localparam int T = 4;

    typedef struct packed {
        logic [31:0] data;
        logic        to;
    } rsp_t;

    logic        iClock;
    logic        iReset;
    logic        iCmdValid;
    logic        iCmdWrite;
    logic [31:0] iCmdAddress;
    logic [31:0] iCmdData;
    logic        oCmdReady;
    logic [31:0] oWriteAddress;
    logic [31:0] oWriteData;
    logic        oWriteValid;
    logic        iWriteAck;
    logic [31:0] oReadAddress;
    logic        oReadValid;
    logic [31:0] iReadData;
    logic        iReadAck;
    logic        oRspValid;
    logic [31:0] oRspData;
    logic        oRspTimeout;
    logic        iRspReady;
    logic [7:0]  oTimeoutCount;

    int   checks     = 0;
    int   errors     = 0;
    int   exp_tcount = 0;
    rsp_t sb[$];

    disp_reg_initiator #(.TIMEOUT_CYCLES(T)) dut (
        .iClock        (iClock),
        .iReset        (iReset),
        .iCmdValid     (iCmdValid),
        .iCmdWrite     (iCmdWrite),
        .iCmdAddress   (iCmdAddress),
        .iCmdData      (iCmdData),
        .oCmdReady     (oCmdReady),
        .oWriteAddress (oWriteAddress),
        .oWriteData    (oWriteData),
        .oWriteValid   (oWriteValid),
        .iWriteAck     (iWriteAck),
        .oReadAddress  (oReadAddress),
        .oReadValid    (oReadValid),
        .iReadData     (iReadData),
        .iReadAck      (iReadAck),
        .oRspValid     (oRspValid),
        .oRspData      (oRspData),
        .oRspTimeout   (oRspTimeout),
        .iRspReady     (iRspReady),
        .oTimeoutCount (oTimeoutCount)
    );

    // Free-running 10 ns clock.
    initial iClock = 1'b0;
    always #5 iClock = ~iClock;

    // Single comparison point: counts the check and reports any difference.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Idle-state outputs as seen during or right after reset.
    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, oCmdReady, 1);
        check({tag, "_wr_valid"}, oWriteValid, 0);
        check({tag, "_rd_valid"}, oReadValid, 0);
        check({tag, "_rsp_valid"}, oRspValid, 0);
        check({tag, "_rsp_data"}, oRspData, 0);
        check({tag, "_rsp_to"}, oRspTimeout, 0);
        check({tag, "_tcount"}, oTimeoutCount, 0);
        check({tag, "_addr"}, oWriteAddress, 0);
    endtask

    // One full transaction. ack_at is the index of the valid cycle in which
    // the ack is raised (negative = never). stray raises iReadAck throughout
    // a write. hold keeps iRspReady low that many cycles in RESP; hold_cmd
    // also presents a competing read command during that time.
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                           input int ack_at, input logic [31:0] rdata, input logic stray,
                           input int hold, input logic hold_cmd);
        int   vcnt;
        int   exp_v;
        logic ack_hit;
        rsp_t exp;
        rsp_t got;

        @(negedge iClock);
        check("idle_cmd_ready", oCmdReady, 1);
        iCmdValid   = 1'b1;
        iCmdWrite   = wr;
        iCmdAddress = addr;
        iCmdData    = data;

        ack_hit  = (ack_at >= 0) && (ack_at < T);
        exp_v    = ack_hit ? ack_at + 1 : T;
        exp.data = (ack_hit && !wr) ? rdata : 32'd0;
        exp.to   = !ack_hit;
        sb.push_back(exp);
        if (!ack_hit && exp_tcount != 255) exp_tcount++;

        @(posedge iClock);
        @(negedge iClock);
        iCmdValid   = 1'b0;
        iCmdAddress = ~addr;
        iCmdData    = ~data;

        vcnt = 0;
        while ((wr ? oWriteValid : oReadValid) && vcnt < 100) begin
            check("bus_addr", wr ? oWriteAddress : oReadAddress, addr);
            if (wr) check("bus_wdata", oWriteData, data);
            check("other_valid_low", wr ? oReadValid : oWriteValid, 0);
            check("busy_cmd_ready", oCmdReady, 0);
            iWriteAck = wr && (vcnt == ack_at);
            iReadAck  = (!wr && (vcnt == ack_at)) || (wr && stray);
            iReadData = (!wr && (vcnt == ack_at)) ? rdata : 32'hDEAD_BEEF;
            vcnt++;
            @(negedge iClock);
        end
        iWriteAck = 1'b0;
        iReadAck  = 1'b0;
        iReadData = 32'hDEAD_BEEF;

        check("valid_cycles", vcnt, exp_v);
        check("rsp_latency", oRspValid, 1);

        for (int i = 0; i < hold; i++) begin
            iRspReady = 1'b0;
            if (hold_cmd) begin
                iCmdValid   = 1'b1;
                iCmdWrite   = 1'b0;
                iCmdAddress = 32'h0000_0099;
            end
            check("hold_rsp_valid", oRspValid, 1);
            check("hold_rsp_data", oRspData, exp.data);
            check("hold_rsp_to", oRspTimeout, exp.to);
            check("hold_cmd_ready", oCmdReady, 0);
            @(negedge iClock);
        end

        iRspReady = 1'b1;
        check("sb_not_empty", sb.size(), 1);
        if (sb.size() > 0) begin
            got = sb.pop_front();
            check("rsp_data", oRspData, got.data);
            check("rsp_timeout", oRspTimeout, got.to);
        end
        check("timeout_count", oTimeoutCount, exp_tcount);

        @(negedge iClock);
        iRspReady = 1'b0;
        check("post_rsp_valid", oRspValid, 0);
        check("post_cmd_ready", oCmdReady, 1);
        check("post_rd_valid", oReadValid, 0);
        check("post_wr_valid", oWriteValid, 0);
        iCmdValid = 1'b0;
    endtask

    initial begin
        iReset      = 1'b0;
        iCmdValid   = 1'b0;
        iCmdWrite   = 1'b0;
        iCmdAddress = '0;
        iCmdData    = '0;
        iWriteAck   = 1'b0;
        iReadAck    = 1'b0;
        iReadData   = 32'hDEAD_BEEF;
        iRspReady   = 1'b0;

        // Reset state.
        repeat (3) @(negedge iClock);
        check_reset_outputs("reset");
        iReset = 1'b1;

        // Acks while idle must not start anything.
        @(negedge iClock);
        iWriteAck = 1'b1;
        iReadAck  = 1'b1;
        @(negedge iClock);
        iWriteAck = 1'b0;
        iReadAck  = 1'b0;
        check("idle_ack_rsp_valid", oRspValid, 0);
        check("idle_ack_wr_valid", oWriteValid, 0);
        check("idle_ack_cmd_ready", oCmdReady, 1);

        // Write acked in its first valid cycle.
        run_txn(1'b1, 32'h0000_0010, 32'hCAFE_F00D, 0, 32'd0, 1'b0, 0, 1'b0);

        // Read acked after three wait cycles.
        run_txn(1'b0, 32'h0000_0020, 32'd0, 3, 32'h1234_5678, 1'b0, 0, 1'b0);

        // Write never acked: times out.
        run_txn(1'b1, 32'h0000_0030, 32'h0BAD_0BAD, -1, 32'd0, 1'b0, 0, 1'b0);

        // Write acked in the final cycle with a stray read ack throughout.
        run_txn(1'b1, 32'h0000_0034, 32'h1111_2222, T - 1, 32'd0, 1'b1, 0, 1'b0);

        // Read with response held for five cycles and a competing command.
        run_txn(1'b0, 32'h0000_0044, 32'd0, 1, 32'hA5A5_5A5A, 1'b0, 5, 1'b1);

        // Read timeout returns zero data.
        run_txn(1'b0, 32'h0000_0048, 32'd0, -1, 32'hFFFF_FFFF, 1'b0, 1, 1'b0);

        // Reset pulsed in the middle of a read wait.
        @(negedge iClock);
        iCmdValid   = 1'b1;
        iCmdWrite   = 1'b0;
        iCmdAddress = 32'h0000_0040;
        @(negedge iClock);
        iCmdValid = 1'b0;
        check("mid_read_valid", oReadValid, 1);
        @(negedge iClock);
        #2 iReset = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        sb.delete();
        exp_tcount = 0;
        @(negedge iClock);
        check("reset_held_cmd_ready", oCmdReady, 1);
        iReset = 1'b1;

        // Enough timeouts to saturate the counter.
        for (int i = 0; i < 300; i++) begin
            run_txn(1'b1, 32'h0000_1000 + i, i, -1, 32'd0, 1'b0, 0, 1'b0);
        end
        check("tcount_saturated", oTimeoutCount, 255);

        // Reset clears the saturated counter.
        @(negedge iClock);
        iReset = 1'b0;
        #1;
        check_reset_outputs("final_reset");
        @(negedge iClock);
        iReset = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
